// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and legal operand widths.
// Imported by the controller; contains no logic.
package serial_add_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single 1-bit full adder, purely combinational; the one arithmetic cell the controller reuses every cycle.
// Zero latency, no state, no flow control.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic w_p;

   assign w_p = x ^ y;
   assign s   = w_p ^ ci;
   assign co  = (x & y) | (ci & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
// Latency WIDTH cycles; start is only sampled in IDLE, so requests during RUN are dropped.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic             w_accept;
   logic             w_last;
   logic             w_s;
   logic             w_co;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum_sh;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_done;

   fa_cell u_fa (
      .x  (r_a_sh[0]),
      .y  (r_b_sh[0]),
      .ci (r_c),
      .s  (w_s),
      .co (w_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = RUN;
            end
         end
         RUN: begin
            if (r_cnt == LAST) begin
               w_last = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Outputs are only rewritten on the final bit, so they hold across later starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_c      <= 1'b0;
         r_cnt    <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_c      <= cin;
            r_cnt    <= '0;
            r_sum_sh <= '0;
         end else if (r_state == RUN) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_c      <= w_co;
            r_cnt    <= r_cnt + 1'b1;
         end
         if (w_last) begin
            r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_cout <= w_co;
            r_done <= 1'b1;
         end
      end
   end

   assign busy = (r_state == RUN);
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=2 instances checked against a plain a+b+cin model
// with cycle-level latency, busy-length and done-pulse expectations.
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst_n;

   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start2, cin2, busy2, done2, cout2;
   logic [1:0] a2, b2, sum2;

   int vectors;
   int miscompares;

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation on either instance; inject_at>=0 pulses a foreign start mid-RUN.
   task automatic do_op(input bit w2, input int unsigned av, input int unsigned bv,
                        input bit ci, input int inject_at, input string tag);
      int unsigned w;
      longint unsigned expv;
      longint unsigned got;
      int n;
      int done_n;
      int busy_cnt;
      int overlap;
      int extra_done;
      bit d;
      bit bz;
      w = w2 ? 2 : 8;
      expv = (longint'(av) + longint'(bv) + longint'(ci)) % (64'd1 << (w + 1));
      if (w2) begin
         a2 = av[1:0]; b2 = bv[1:0]; cin2 = ci; start2 = 1'b1;
      end else begin
         a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; start8 = 1'b1;
      end
      tick();  // E0
      start2 = 1'b0;
      start8 = 1'b0;
      n = 0;
      done_n = -1;
      busy_cnt = 0;
      overlap = 0;
      extra_done = 0;
      while (done_n < 0 && n <= int'(w) + 4) begin
         d  = w2 ? done2 : done8;
         bz = w2 ? busy2 : busy8;
         if (d && bz) overlap++;
         if (bz) busy_cnt++;
         if (d) done_n = n;
         else begin
            if (n == inject_at) begin
               if (w2) begin a2 = 2'd1; b2 = 2'd1; start2 = 1'b1; end
               else begin a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; end
            end
            tick();
            start2 = 1'b0;
            start8 = 1'b0;
            n++;
         end
      end
      got = w2 ? {63'd0, cout2, sum2} : {55'd0, cout8, sum8};
      vectors++;
      if (done_n != int'(w)) begin
         miscompares++;
         $display("FAIL %s latency: done after edge E0+%0d, required E0+%0d", tag, done_n, w);
      end
      vectors++;
      if (busy_cnt != int'(w)) begin
         miscompares++;
         $display("FAIL %s busy_len: %0d cycles, required %0d", tag, busy_cnt, w);
      end
      vectors++;
      if (overlap != 0) begin
         miscompares++;
         $display("FAIL %s busy_done_overlap: %0d cycles, required 0", tag, overlap);
      end
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s result: {cout,sum}=0x%0h, required 0x%0h", tag, got, expv);
      end
      for (int k = 0; k < (inject_at >= 0 ? 12 : 1); k++) begin
         tick();
         if ((w2 ? done2 : done8) !== 1'b0) extra_done++;
      end
      vectors++;
      if (extra_done != 0) begin
         miscompares++;
         $display("FAIL %s done_pulse_width: %0d extra done cycles, required 0", tag, extra_done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      tick();
      tick();
      vectors++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset8: busy/done/cout/sum=0x%0h, required 0", {busy8, done8, cout8, sum8});
      end
      vectors++;
      if ({busy2, done2, cout2, sum2} !== 5'd0) begin
         miscompares++;
         $display("FAIL reset2: busy/done/cout/sum=0x%0h, required 0", {busy2, done2, cout2, sum2});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      do_op(1'b0, 32'h5A, 32'h3C, 1'b0, -1, "basic_5a_3c");
   endtask

   task automatic test_carry_chain();
      do_op(1'b0, 32'hFF, 32'h01, 1'b0, -1, "carry_ff_01");
      do_op(1'b0, 32'hFF, 32'hFF, 1'b1, -1, "carry_ff_ff_c1");
   endtask

   task automatic test_start_in_run();
      do_op(1'b0, 32'h5A, 32'h3C, 1'b0, 3, "start_ignored");
   endtask

   task automatic test_back_to_back();
      logic [7:0] ops_a [3];
      logic [7:0] ops_b [3];
      logic [7:0] prev;
      int k;
      int ncyc;
      int last_done;
      ops_a[0] = 8'h10; ops_b[0] = 8'h01;
      ops_a[1] = 8'h20; ops_b[1] = 8'h02;
      ops_a[2] = 8'h30; ops_b[2] = 8'h03;
      prev = sum8;
      k = 0;
      ncyc = 0;
      last_done = -1;
      a8 = ops_a[0]; b8 = ops_b[0]; cin8 = 1'b0; start8 = 1'b1;
      while (k < 3 && ncyc < 40) begin
         tick();
         ncyc++;
         vectors++;
         if (done8) begin
            if (sum8 !== ops_a[k] + ops_b[k] || cout8 !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_result%0d: cout=%0b sum=0x%0h, required cout=0 sum=0x%0h",
                        k, cout8, sum8, ops_a[k] + ops_b[k]);
            end
            if (k > 0) begin
               vectors++;
               if (ncyc - last_done != 9) begin
                  miscompares++;
                  $display("FAIL b2b_spacing%0d: %0d cycles, required 9", k, ncyc - last_done);
               end
            end
            last_done = ncyc;
            prev = sum8;
            k++;
            if (k < 3) begin
               a8 = ops_a[k]; b8 = ops_b[k];
            end else begin
               start8 = 1'b0;
            end
         end else if (sum8 !== prev) begin
            miscompares++;
            $display("FAIL b2b_hold: sum=0x%0h changed without done, required 0x%0h", sum8, prev);
         end
      end
      start8 = 1'b0;
      vectors++;
      if (k != 3) begin
         miscompares++;
         $display("FAIL b2b_count: %0d results, required 3", k);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int spurious;
      a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
      tick();  // E0
      start8 = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         miscompares++;
         $display("FAIL mid_reset: busy/done/cout/sum=0x%0h, required 0", {busy8, done8, cout8, sum8});
      end
      tick();
      tick();
      rst_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8 || busy8 || sum8 != 8'h00) spurious++;
      end
      vectors++;
      if (spurious != 0) begin
         miscompares++;
         $display("FAIL mid_reset_quiet: %0d cycles with activity, required 0", spurious);
      end
      do_op(1'b0, 32'h7F, 32'h01, 1'b0, -1, "after_reset_7f_01");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         do_op(1'b0, $urandom_range(255), $urandom_range(255), 1'($urandom_range(1)), -1, "random8");
      end
   endtask

   task automatic test_width2_exhaustive();
      for (int av = 0; av < 4; av++)
         for (int bv = 0; bv < 4; bv++)
            for (int c = 0; c < 2; c++)
               do_op(1'b1, av, bv, c[0], -1, "w2_exhaustive");
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_basic();
      test_carry_chain();
      test_start_in_run();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      test_width2_exhaustive();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
